// File: rtl/modexp_ctrl.sv
// Montgomery-domain left-to-right square-and-multiply controller for 256-bit modular exponentiation.
// Drives an external Montgomery multiplier and issues one operation at a time.
module modexp_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] base,
  input  logic [255:0] exp,
  input  logic [255:0] mod,
  input  logic [255:0] r2,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [255:0] result,
  output logic [255:0] mm_a,
  output logic [255:0] mm_b,
  output logic [255:0] mm_n,
  output logic         mm_start,
  input  logic         mm_done,
  input  logic [255:0] mm_out
);

  typedef enum logic [2:0] {IDLE, CHK, PRE_M, PRE_X, SQR, MUL, POST, FIN} state_t;

  state_t       r_state, w_state_nxt;
  logic [255:0] r_m, r_e, r_n, r_r2, r_mb, r_x, r_result;
  logic [255:0] r_mm_a, r_mm_b, r_mm_n, w_a, w_b, w_x_cur;
  logic [7:0]   r_idx;
  logic         r_err, r_mm_start, r_wait;
  logic         w_ack, w_accept, w_bad, w_launch, w_dec, w_bit;

  // A completion only counts while an issued operation is outstanding.
  assign w_ack = r_wait & ~r_mm_start & mm_done;
  assign w_bit = r_e[r_idx];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bad       = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      IDLE:  if (start) begin w_accept = 1'b1; w_state_nxt = CHK; end
      CHK: begin
        if (!r_n[0] || r_n == 256'd1) begin
          w_bad       = 1'b1;
          w_state_nxt = FIN;
        end else begin
          w_launch    = 1'b1;
          w_state_nxt = PRE_M;
        end
      end
      PRE_M: if (w_ack) begin w_launch = 1'b1; w_state_nxt = PRE_X; end
      PRE_X: if (w_ack) begin w_launch = 1'b1; w_state_nxt = SQR; end
      SQR: if (w_ack) begin
        w_launch = 1'b1;
        if (w_bit)              w_state_nxt = MUL;
        else if (r_idx == 8'd0) w_state_nxt = POST;
        else                    w_state_nxt = SQR;
      end
      MUL: if (w_ack) begin
        w_launch    = 1'b1;
        w_state_nxt = (r_idx == 8'd0) ? POST : SQR;
      end
      POST:    if (w_ack) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands for the next launch use the product being captured this cycle.
  always_comb begin
    w_x_cur = (w_ack && (r_state == PRE_X || r_state == SQR || r_state == MUL)) ? mm_out : r_x;
    w_a     = 256'd0;
    w_b     = 256'd0;
    case (w_state_nxt)
      PRE_M:   begin w_a = r_m;     w_b = r_r2;    end
      PRE_X:   begin w_a = 256'd1;  w_b = r_r2;    end
      SQR:     begin w_a = w_x_cur; w_b = w_x_cur; end
      MUL:     begin w_a = w_x_cur; w_b = r_mb;    end
      POST:    begin w_a = w_x_cur; w_b = 256'd1;  end
      default: begin w_a = 256'd0;  w_b = 256'd0;  end
    endcase
  end

  assign w_dec = w_ack && r_idx != 8'd0 &&
                 ((r_state == SQR && !w_bit) || r_state == MUL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m <= '0; r_e <= '0; r_n <= '0; r_r2 <= '0;
      r_mb <= '0; r_x <= '0; r_result <= '0;
      r_mm_a <= '0; r_mm_b <= '0; r_mm_n <= '0;
      r_idx <= '0; r_err <= 1'b0; r_mm_start <= 1'b0; r_wait <= 1'b0;
    end else begin
      r_mm_start <= w_launch;
      if (w_accept) begin
        r_m <= base; r_e <= exp; r_n <= mod; r_r2 <= r2;
        r_mb <= '0; r_x <= '0; r_result <= '0;
        r_idx <= 8'd255;
        r_err <= 1'b0;
      end
      if (w_launch) begin
        r_wait <= 1'b1;
        r_mm_a <= w_a;
        r_mm_b <= w_b;
        r_mm_n <= r_n;
      end else if (w_ack) begin
        r_wait <= 1'b0;
      end
      if (w_ack) begin
        case (r_state)
          PRE_M:          r_mb     <= mm_out;
          PRE_X, SQR, MUL: r_x     <= mm_out;
          POST:           r_result <= mm_out;
          default:        ;
        endcase
      end
      if (w_dec) r_idx <= r_idx - 8'd1;
      if (w_bad) begin
        r_err    <= 1'b1;
        r_result <= '0;
      end
    end
  end

  assign busy     = (r_state != IDLE) && (r_state != FIN);
  assign done     = (r_state == FIN);
  assign err      = r_err;
  assign result   = r_result;
  assign mm_a     = r_mm_a;
  assign mm_b     = r_mm_b;
  assign mm_n     = r_mm_n;
  assign mm_start = r_mm_start;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: 5-cycle Montgomery multiplier model plus a plain
// modular-exponentiation reference, directed and random operations.
module tb_modexp_ctrl;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [255:0] base_i, exp_i, mod_i, r2_i;
  logic         busy, done, err, mm_start, mm_done;
  logic [255:0] result, mm_a, mm_b, mm_n, mm_out;

  logic         mdl_done = 1'b0;
  logic [255:0] mdl_out = '0;
  logic [255:0] la, lb, ln;
  int           mdl_cnt = 0;
  int           n_starts = 0, n_dones = 0, n_unstable = 0, n_overlap = 0;
  logic         inj_done;
  logic [255:0] inj_val;
  int           n_assert = 0, n_fail = 0;

  assign mm_done = mdl_done | inj_done;
  assign mm_out  = inj_done ? inj_val : mdl_out;

  always #5 clk = ~clk;

  modexp_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .base(base_i), .exp(exp_i), .mod(mod_i), .r2(r2_i),
    .busy(busy), .done(done), .err(err), .result(result),
    .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_start(mm_start), .mm_done(mm_done), .mm_out(mm_out)
  );

  function automatic logic [255:0] mont(input logic [255:0] a, b, n);
    logic [513:0] p, q;
    p = {258'b0, a} * {258'b0, b};
    for (int i = 0; i < 256; i++) begin
      if (p[0]) p = p + {258'b0, n};
      p = p >> 1;
    end
    q = p % {258'b0, n};
    return q[255:0];
  endfunction

  function automatic logic [255:0] ref_modexp(input logic [255:0] n, m, e);
    logic [511:0] r, b, nn;
    nn = {256'b0, n};
    b  = {256'b0, m} % nn;
    r  = 512'd1 % nn;
    for (int i = 255; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * b) % nn;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] calc_r2(input logic [255:0] n);
    logic [512:0] one, q;
    one = 513'd1 << 512;
    q   = one % {257'b0, n};
    return q[255:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Multiplier model: latches operands on mm_start, answers 5 cycles later.
  always @(negedge clk) begin
    if (mm_start) n_starts++;
    if (done) n_dones++;
    mdl_done = 1'b0;
    if (rst) begin
      mdl_cnt = 0;
    end else if (mdl_cnt > 0) begin
      if (mm_start) n_overlap++;
      if (mm_a !== la || mm_b !== lb || mm_n !== ln) n_unstable++;
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_done = 1'b1;
        mdl_out  = mont(la, lb, ln);
      end
    end else if (mm_start) begin
      la = mm_a; lb = mm_b; ln = mm_n;
      mdl_cnt = 5;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [255:0] n, r, m, e);
    start = 1'b1; mod_i = n; r2_i = r; base_i = m; exp_i = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic [255:0] n, r, m, e,
                           input logic [255:0] exp_res, input logic exp_err,
                           input int exp_starts, output int cyc);
    int s0, d0;
    s0 = n_starts; d0 = n_dones;
    launch(n, r, m, e);
    chk({tag, " busy"}, 256'(busy), 256'd1);
    wait_done(6000, cyc);
    chk({tag, " done"}, 256'(done), 256'd1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " err"}, 256'(err), 256'(exp_err));
    chk({tag, " busy@done"}, 256'(busy), 256'd0);
    @(negedge clk);
    chk({tag, " done pulse"}, 256'(done), 256'd0);
    chk({tag, " mm_starts"}, 256'(n_starts - s0), 256'(exp_starts));
    chk({tag, " done count"}, 256'(n_dones - d0), 256'd1);
  endtask

  initial begin
    int cyc, s0;
    logic [255:0] n, m, e;
    rst = 1'b1; start = 1'b0; inj_done = 1'b0; inj_val = '0;
    base_i = '0; exp_i = '0; mod_i = '0; r2_i = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 256'(busy), 256'd0);
    chk("rst done", 256'(done), 256'd0);
    chk("rst err", 256'(err), 256'd0);
    chk("rst mm_start", 256'(mm_start), 256'd0);
    chk("rst result", result, 256'd0);
    chk("rst mm_a", mm_a, 256'd0);
    chk("rst mm_b", mm_b, 256'd0);
    chk("rst mm_n", mm_n, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    run_check("e3", 256'd13, 256'd9, 256'd4, 256'd3, 256'd12, 1'b0, 261, cyc);
    run_check("n10", 256'd10, 256'd9, 256'd4, 256'd3, 256'd0, 1'b1, 0, cyc);
    chk("n10 latency", 256'(cyc <= 2), 256'd1);
    run_check("n1", 256'd1, 256'd0, 256'd0, 256'd7, 256'd0, 1'b1, 0, cyc);
    run_check("e0", 256'd13, 256'd9, 256'd4, 256'd0, 256'd1, 1'b0, 259, cyc);
    run_check("m0", 256'd13, 256'd9, 256'd0, 256'd5, 256'd0, 1'b0, 261, cyc);

    // Second start while busy must be ignored.
    s0 = n_starts;
    launch(256'd13, 256'd9, 256'd4, 256'd3);
    repeat (20) @(negedge clk);
    launch(256'd13, 256'd9, 256'd5, 256'd7);
    wait_done(6000, cyc);
    chk("busy-start done", 256'(done), 256'd1);
    chk("busy-start result", result, 256'd12);
    @(negedge clk);
    chk("busy-start mm_starts", 256'(n_starts - s0), 256'd261);

    // Reset while a squaring is outstanding, then a stale completion.
    launch(256'd13, 256'd9, 256'd4, 256'd3);
    repeat (40) @(negedge clk);
    cyc = 0;
    while (!(busy && !mm_start && mdl_cnt > 1) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid-op wait", 256'(cyc < 50), 256'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 256'(busy), 256'd0);
    chk("midrst result", result, 256'd0);
    chk("midrst mm_a", mm_a, 256'd0);
    chk("midrst mm_start", 256'(mm_start), 256'd0);
    repeat (2) @(negedge clk);
    inj_done = 1'b1; inj_val = rnd256();
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk("stale busy", 256'(busy), 256'd0);
    chk("stale done", 256'(done), 256'd0);
    chk("stale result", result, 256'd0);
    run_check("after-rst", 256'd13, 256'd9, 256'd2, 256'd5, 256'd6, 1'b0, 261, cyc);

    // Back-to-back: start held through the done cycle, then start one cycle after done.
    launch(256'd13, 256'd9, 256'd4, 256'd3);
    wait_done(6000, cyc);
    chk("b2b A result", result, 256'd12);
    s0 = n_starts;
    start = 1'b1; mod_i = 256'd13; r2_i = 256'd9; base_i = 256'd2; exp_i = 256'd5;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(6000, cyc);
    chk("b2b B done", 256'(done), 256'd1);
    chk("b2b B result", result, 256'd6);
    @(negedge clk);
    chk("b2b B mm_starts", 256'(n_starts - s0), 256'd261);
    run_check("b2b C", 256'd13, 256'd9, 256'd7, 256'd2, 256'd10, 1'b0, 260, cyc);

    for (int k = 0; k < 3; k++) begin
      n = rnd256() | 256'd1;
      if (n == 256'd1) n = 256'd13;
      m = rnd256() % n;
      e = rnd256();
      run_check($sformatf("rand%0d", k), n, calc_r2(n), m, e, ref_modexp(n, m, e),
                1'b0, 259 + $countones(e), cyc);
    end

    chk("operand stability", 256'(n_unstable), 256'd0);
    chk("overlapping launches", 256'(n_overlap), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
